// File: rtl/udp_vlg_pkg.sv
// Shared types and constants for the UDP receive path.
//   strm_t      : byte stream beat (dat, val, sof, eof, err)
//   mac_hdr_t   : Ethernet header fields carried as metadata
//   ipv4_hdr_t  : IPv4 header fields carried as metadata
//   udp_hdr_t   : 8-byte UDP header, big-endian field order
//   ipv4_meta_t : metadata delivered with the IPv4 payload stream
//   udp_meta_t  : metadata delivered with the UDP payload stream
//   dev_t       : device configuration
package udp_vlg_pkg;

  localparam int         UDP_HDR_LEN = 8;
  localparam logic [7:0] UDP         = 8'd17;

  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } strm_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
  } mac_hdr_t;

  typedef struct packed {
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] cks;
  } udp_hdr_t;

  typedef struct packed {
    ipv4_hdr_t   ipv4_hdr;
    mac_hdr_t    mac_hdr;
    logic [15:0] pld_len;
  } ipv4_meta_t;

  typedef struct packed {
    udp_hdr_t    udp_hdr;
    ipv4_hdr_t   ipv4_hdr;
    mac_hdr_t    mac_hdr;
    logic [15:0] pld_len;
  } udp_meta_t;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
  } dev_t;

  typedef enum logic [1:0] {IDLE, HDR, PLD, SKIP} udp_rx_state_t;

  // Pseudo-header sum without the UDP length term; the length is folded in
  // once the length field itself has been received.
  function automatic logic [31:0] pseudo_sum(input ipv4_hdr_t h);
    return 32'(h.src_ip[31:16]) + 32'(h.src_ip[15:0]) +
           32'(h.dst_ip[31:16]) + 32'(h.dst_ip[15:0]) + 32'(UDP);
  endfunction

endpackage

// File: rtl/udp_vlg_if.sv
// Stream + metadata bundles between protocol layers.
//   ipv4 : IPv4 payload stream and IPv4/MAC metadata
//   udp  : UDP payload stream and UDP/IPv4/MAC metadata
// Modports: in_rx (consumer side), out_rx (producer side).
interface ipv4;
  import udp_vlg_pkg::*;
  strm_t      strm;
  ipv4_meta_t meta;
  modport in_rx  (input  strm, meta);
  modport out_rx (output strm, meta);
endinterface

interface udp;
  import udp_vlg_pkg::*;
  strm_t     strm;
  udp_meta_t meta;
  modport in_rx  (input  strm, meta);
  modport out_rx (output strm, meta);
endinterface

// File: rtl/udp_vlg_cks.sv
// Streaming one's-complement checksum accumulator.
//   clk, rst   : clock, synchronous active-high reset
//   load       : restart the sum at load_val (may coincide with byte_en)
//   load_val   : preload value (pseudo-header partial sum)
//   byte_en    : byte_dat is the next byte of the 16-bit big-endian stream
//   word_en    : add word_dat as an extra 16-bit term
//   sum        : twice-folded 16-bit sum
//   ok         : sum equals 0xFFFF
module udp_vlg_cks (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        byte_en,
  input  logic [7:0]  byte_dat,
  input  logic        word_en,
  input  logic [15:0] word_dat,
  output logic [15:0] sum,
  output logic        ok
);

  logic [31:0] acc;
  logic        odd;   // next byte is the low half of a word
  logic [31:0] base;
  logic [31:0] byte_term;
  logic [31:0] word_term;
  logic [16:0] fold1;
  logic [16:0] fold2;

  // Even bytes go to the high half, odd bytes to the low half, so a final
  // odd byte is implicitly padded with 0x00.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    base      = load ? load_val : acc;
    byte_term = '0;
    if (byte_en) begin
      byte_term = (load || !odd) ? {16'h0, byte_dat, 8'h00} : {24'h0, byte_dat};
    end
    word_term = word_en ? {16'h0, word_dat} : '0;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      odd <= 1'b0;
    end else begin
      if (load || byte_en || word_en) acc <= base + byte_term + word_term;
      if (load)         odd <= byte_en;
      else if (byte_en) odd <= !odd;
    end
  end

  // A second fold absorbs the carry of the first; it cannot carry again.
  always_comb begin
    fold1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    fold2 = {1'b0, fold1[15:0]} + 17'(fold1[16]);
    sum   = fold2[15:0];
    ok    = (fold2[15:0] == 16'hFFFF);
  end

endmodule

// File: rtl/udp_vlg_rx.sv
// UDP receive parser behind the IPv4 receiver.
//   clk, rst : clock, synchronous active-high reset
//   ipv4     : IPv4 payload stream + IPv4/MAC metadata (in)
//   udp      : UDP payload stream + UDP metadata (out), 2-cycle latency
//   dev      : device configuration (only relevant to the datagram print)
// Parameters: VERBOSE (datagram print), CKS_EN (checksum verification).
module udp_vlg_rx
  import udp_vlg_pkg::*;
#(
  parameter bit VERBOSE = 1'b1,
  parameter bit CKS_EN  = 1'b1
) (
  input logic  clk,
  input logic  rst,
  ipv4.in_rx   ipv4,
  udp.out_rx   udp,
  input dev_t  dev
);

  udp_rx_state_t state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;      // index of the incoming UDP byte
  udp_hdr_t      hdr_q, hdr_nxt;
  ipv4_hdr_t     ip_q;
  mac_hdr_t      mac_q;
  logic [15:0]   iplen_q;
  strm_t         s1_q, s1_d;        // s1.err carries truncation only
  strm_t         out_d;
  strm_t         rx;

  logic          hdr_shift, cap, last, hdr_ok;
  logic          cks_load, cks_byte, cks_word, cks_ok, cks_bad;
  logic [15:0]   cks_sum;
  logic [15:0]   len_m1;

  // The per-datagram print is a simulation feature; the synthesizable core
  // keeps the parameter and the config port for drop-in compatibility.
  logic unused_cfg;
  assign unused_cfg = ^{VERBOSE, dev, cks_sum};

  assign rx      = ipv4.strm;
  assign hdr_nxt = {hdr_q[55:0], rx.dat};
  assign len_m1  = hdr_q.length - 16'd1;
  assign hdr_ok  = (hdr_nxt.length > 16'(UDP_HDR_LEN)) && (hdr_nxt.length <= iplen_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s1_d      = '0;
    hdr_shift = 1'b0;
    cap       = 1'b0;
    last      = 1'b0;
    cks_load  = 1'b0;
    cks_byte  = 1'b0;
    cks_word  = 1'b0;
    if (rx.val) begin
      unique case (state_q)
        IDLE: begin
          if (rx.sof && ipv4.meta.ipv4_hdr.proto == UDP) begin
            cap       = 1'b1;
            cks_load  = 1'b1;
            cks_byte  = 1'b1;
            hdr_shift = 1'b1;
            cnt_d     = 16'd1;
            state_d   = (rx.eof || rx.err) ? IDLE : HDR;
          end
        end
        HDR: begin
          hdr_shift = 1'b1;
          cks_byte  = 1'b1;
          cks_word  = (cnt_q == 16'd5);   // pseudo-header length term
          cnt_d     = cnt_q + 16'd1;
          if (rx.eof || rx.err)   state_d = IDLE;
          else if (cnt_q == 16'd7) state_d = hdr_ok ? PLD : SKIP;
        end
        PLD: begin
          cks_byte = 1'b1;
          cnt_d    = cnt_q + 16'd1;
          last     = (cnt_q == len_m1);
          s1_d.val = 1'b1;
          s1_d.dat = rx.dat;
          s1_d.sof = (cnt_q == 16'(UDP_HDR_LEN));
          s1_d.eof = last || rx.eof || rx.err;
          s1_d.err = rx.err || (rx.eof && !last);
          if (rx.eof || rx.err) state_d = IDLE;
          else if (last)        state_d = SKIP;
        end
        SKIP: begin
          if (rx.eof || rx.err) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      ip_q    <= '0;
      mac_q   <= '0;
      iplen_q <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      if (hdr_shift) hdr_q <= hdr_nxt;
      if (cap) begin
        ip_q    <= ipv4.meta.ipv4_hdr;
        mac_q   <= ipv4.meta.mac_hdr;
        iplen_q <= ipv4.meta.pld_len;
      end
    end
  end

  udp_vlg_cks u_cks (
    .clk      (clk),
    .rst      (rst),
    .load     (cks_load),
    .load_val (pseudo_sum(ipv4.meta.ipv4_hdr)),
    .byte_en  (cks_byte),
    .byte_dat (rx.dat),
    .word_en  (cks_word),
    .word_dat ({hdr_q[7:0], rx.dat}),
    .sum      (cks_sum),
    .ok       (cks_ok)
  );

  // The accumulator already holds the last byte when s1 carries eof, so the
  // second stage only needs the fold result.
  assign cks_bad = CKS_EN && (hdr_q.cks != 16'h0) && !cks_ok;

  always_comb begin
    out_d     = s1_q;
    out_d.err = s1_q.eof && (s1_q.err || cks_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      udp.strm <= '0;
      udp.meta <= '0;
    end else begin
      udp.strm <= out_d;
      if (s1_q.sof) begin
        udp.meta <= '{udp_hdr:  hdr_q,
                      ipv4_hdr: ip_q,
                      mac_hdr:  mac_q,
                      pld_len:  hdr_q.length - 16'(UDP_HDR_LEN)};
      end
    end
  end

endmodule

// File: tb/tb_udp_vlg_rx.sv
module tb_udp_vlg_rx;
  import udp_vlg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  dev_t dev;
  always #5 clk = ~clk;

  ipv4 ipv4_if();
  udp  udp_if();

  udp_vlg_rx dut (
    .clk  (clk),
    .rst  (rst),
    .ipv4 (ipv4_if),
    .udp  (udp_if),
    .dev  (dev)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
    logic       err;
    int         cyc;
  } beat_t;

  beat_t      out_q[$];
  logic [7:0] pkt[64];
  int         in_cyc[64];
  int         checks = 0;
  int         errors = 0;

  always @(negedge clk) begin
    if (udp_if.strm.val)
      out_q.push_back('{udp_if.strm.dat, udp_if.strm.sof, udp_if.strm.eof,
                        udp_if.strm.err, cyc});
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_ip(input logic [7:0] proto, input logic [15:0] pld_len);
    ipv4_if.meta.ipv4_hdr.ttl    = 8'd64;
    ipv4_if.meta.ipv4_hdr.proto  = proto;
    ipv4_if.meta.ipv4_hdr.src_ip = 32'hC0A8010A;
    ipv4_if.meta.ipv4_hdr.dst_ip = 32'hC0A80101;
    ipv4_if.meta.mac_hdr         = '{48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800};
    ipv4_if.meta.pld_len         = pld_len;
  endtask

  task automatic set_udp(input logic [15:0] len, input logic [15:0] cks);
    logic [15:0] sp, dp;
    sp = 16'd5000;
    dp = 16'd1234;
    pkt[0] = sp[15:8];  pkt[1] = sp[7:0];
    pkt[2] = dp[15:8];  pkt[3] = dp[7:0];
    pkt[4] = len[15:8]; pkt[5] = len[7:0];
    pkt[6] = cks[15:8]; pkt[7] = cks[7:0];
  endtask

  task automatic set_dead;
    pkt[8] = 8'hDE; pkt[9] = 8'hAD; pkt[10] = 8'hBE; pkt[11] = 8'hEF;
  endtask

  // One byte per cycle; optional idle cycle before byte gap_at and a
  // one-cycle reset pulse alongside byte rst_at. Leaves the last byte driven.
  task automatic send(input int n, input int gap_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i > 0 && i - 1 == rst_at) begin
        check("rst_mid_strm", udp_if.strm, '0);
        check("rst_mid_pld_len", udp_if.meta.pld_len, 16'd0);
      end
      if (i == gap_at) begin
        ipv4_if.strm = '0;
        @(posedge clk); #1;
      end
      rst               = (i == rst_at);
      ipv4_if.strm.dat  = pkt[i];
      ipv4_if.strm.val  = 1'b1;
      ipv4_if.strm.sof  = (i == 0);
      ipv4_if.strm.eof  = (i == n - 1);
      ipv4_if.strm.err  = 1'b0;
      in_cyc[i]         = cyc;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    rst          = 1'b0;
    ipv4_if.strm = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input int n, input logic exp_err);
    check({tag, "_cnt"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      check($sformatf("%s_dat%0d", tag, i), out_q[i].dat, pkt[8 + i]);
      check($sformatf("%s_flg%0d", tag, i), {out_q[i].sof, out_q[i].eof, out_q[i].err},
            {i == 0, i == n - 1, (i == n - 1) && exp_err});
      check($sformatf("%s_lat%0d", tag, i), out_q[i].cyc, in_cyc[8 + i] + 2);
    end
    out_q.delete();
  endtask

  initial begin
    rst          = 1'b1;
    dev          = '{48'h02_00_00_00_00_01, 32'hC0A80101};
    ipv4_if.strm = '0;
    ipv4_if.meta = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strm", udp_if.strm, '0);
    check("rst_udp_hdr", udp_if.meta.udp_hdr, '0);
    check("rst_pld_len", udp_if.meta.pld_len, 16'd0);
    rst = 1'b0;
    idle(2);

    // Valid datagram, gap before the third payload byte.
    set_ip(UDP, 16'd12); set_udp(16'd12, 16'hC682); set_dead();
    send(12, 10, -1); idle(4);
    check_stream("valid", 4, 1'b0);
    check("valid_sport", udp_if.meta.udp_hdr.src_port, 16'd5000);
    check("valid_dport", udp_if.meta.udp_hdr.dst_port, 16'd1234);
    check("valid_pld_len", udp_if.meta.pld_len, 16'd4);
    check("valid_src_ip", udp_if.meta.ipv4_hdr.src_ip, 32'hC0A8010A);

    // Checksum off by one.
    set_udp(16'd12, 16'hC683);
    send(12, -1, -1); idle(4);
    check_stream("badcks", 4, 1'b1);

    // Odd payload, no checksum.
    set_ip(UDP, 16'd11); set_udp(16'd11, 16'h0000);
    pkt[8] = 8'h01; pkt[9] = 8'h02; pkt[10] = 8'h03;
    send(11, -1, -1); idle(4);
    check_stream("zerocks", 3, 1'b0);
    check("zerocks_pld_len", udp_if.meta.pld_len, 16'd3);

    // Odd payload, correct checksum (pads the final byte).
    set_udp(16'd11, 16'h6020);
    send(11, -1, -1); idle(4);
    check_stream("oddcks", 3, 1'b0);

    // TCP datagram: nothing forwarded.
    set_ip(8'd6, 16'd12); set_udp(16'd12, 16'hC682); set_dead();
    send(12, -1, -1); idle(4);
    check("tcp_cnt", out_q.size(), 0);
    out_q.delete();

    // Header-only datagram, then a valid one back-to-back.
    set_ip(UDP, 16'd8); set_udp(16'd8, 16'h0000);
    send(8, -1, -1);
    set_ip(UDP, 16'd12); set_udp(16'd12, 16'hC682); set_dead();
    send(12, -1, -1); idle(4);
    check_stream("b2b", 4, 1'b0);

    // IPv4 padding beyond the UDP length is dropped.
    set_ip(UDP, 16'd18); set_udp(16'd12, 16'hC682); set_dead();
    for (int i = 12; i < 18; i++) pkt[i] = 8'h55;
    send(18, -1, -1); idle(4);
    check_stream("pad", 4, 1'b0);

    // UDP length larger than the bytes delivered.
    set_ip(UDP, 16'd20); set_udp(16'd20, 16'h0000); set_dead();
    send(12, -1, -1); idle(4);
    check_stream("trunc", 4, 1'b1);

    // Reset during payload: only the first payload byte escaped beforehand.
    set_ip(UDP, 16'd12); set_udp(16'd12, 16'hC682); set_dead();
    send(12, -1, 10); idle(4);
    check("rst_pkt_cnt", out_q.size(), 1);
    if (out_q.size() >= 1)
      check("rst_pkt_beat0", {out_q[0].dat, out_q[0].sof, out_q[0].eof}, {8'hDE, 1'b1, 1'b0});
    out_q.delete();
    send(12, -1, -1); idle(4);
    check_stream("post_rst", 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
